regfile_mp: RTL

- Parametrised successor to the single-read-port 64-bit register file.
- Adds configurable width, depth and read-port count, per-byte write masking, and registered reads with a valid strobe.
- Adds a sequential background clear engine that zeroes the array one entry per cycle on request.
- Sits in the datapath as the shared operand store; the register-access logic is the write master and the consumers are read clients.

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 123 ++++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: one write master (register-access
// logic) drives writes, read requests and clear; the register file is the slave.
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       reg_write;
  logic [ADDR_W-1:0]          w_addr;
  logic [DATA_W-1:0]          w_data;
  logic [DATA_W/8-1:0]        w_mask;
  logic [NUM_RD-1:0]          r_en;
  logic [NUM_RD*ADDR_W-1:0]   r_addr;
  logic [NUM_RD*DATA_W-1:0]   r_data;
  logic [NUM_RD-1:0]          r_valid;
  logic                       clr_req;
  logic                       busy;
  logic                       wr_drop;

  modport master (
    output reg_write, w_addr, w_data, w_mask, r_en, r_addr, clr_req,
    input  r_data, r_valid, busy, wr_drop
  );

  modport slave (
    input  reg_write, w_addr, w_data, w_mask, r_en, r_addr, clr_req,
    output r_data, r_valid, busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-masked writes, registered
// reads and a background clear sweep. Define RF_BYPASS_EN for write-through reads.
module regfile_mp #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 0
) (
  input  logic         clk,
  input  logic         srst,
  regfile_mp_if.slave  bus
);
  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   r_data_q [NUM_RD];
  logic [DATA_W-1:0]   r_data_d [NUM_RD];
  logic [NUM_RD-1:0]   r_valid_q, r_valid_d;
  logic                wr_drop_q, wr_drop_d;

  logic [ADDR_W-1:0]   rd_addr [NUM_RD];
  logic [DATA_W-1:0]   byte_en;
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    byte_en = '0;
    for (int k = 0; k < NB; k++) byte_en[8*k +: 8] = {8{bus.w_mask[k]}};
  end

  // Writes lose to a running sweep and to the sweep request itself.
  always_comb begin
    wr_ok = bus.reg_write && (state_q == IDLE) && !bus.clr_req && in_range(bus.w_addr)
            && !((ZERO_REG0 != 0) && (bus.w_addr == '0));
    wr_merged = (mem_q[bus.w_addr] & ~byte_en) | (bus.w_data & byte_en);
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_d     = mem_q;
    wr_drop_d = bus.reg_write && !wr_ok;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        mem_d[clr_cnt_q] = '0;
        if (32'(clr_cnt_q) == DEPTH - 1) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ok) mem_d[bus.w_addr] = wr_merged;
  end

  // Reads during a sweep return 0 because the array is mid-invalidation.
  always_comb begin
    r_valid_d = bus.r_en;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr[p]  = bus.r_addr[p*ADDR_W +: ADDR_W];
      r_data_d[p] = r_data_q[p];
      if (bus.r_en[p]) begin
        r_data_d[p] = '0;
        if ((state_q == IDLE) && in_range(rd_addr[p])) begin
          r_data_d[p] = mem_q[rd_addr[p]];
`ifdef RF_BYPASS_EN
          if (wr_ok && (bus.w_addr == rd_addr[p])) r_data_d[p] = wr_merged;
`endif
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // flops sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      r_valid_q <= '0;
      wr_drop_q <= 1'b0;
      for (int p = 0; p < NUM_RD; p++) r_data_q[p] <= '0;
      // NOTE: the array must zero in a single edge on reset, so it is built
      // from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      r_valid_q <= r_valid_d;
      wr_drop_q <= wr_drop_d;
      for (int p = 0; p < NUM_RD; p++) r_data_q[p] <= r_data_d[p];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.busy    = (state_q == CLEAR);
  assign bus.wr_drop = wr_drop_q;
  assign bus.r_valid = r_valid_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign bus.r_data[p*DATA_W +: DATA_W] = r_data_q[p];
  end
endmodule
